interp_upconv: RTL

- Parametrised successor to the fixed 20-bit interpolator + fs/4 mixer pair.
- Accepts signed baseband samples at the slow rate via a valid/ready handshake, upsamples by 2**RATIO_LOG2 (zero-order hold or linear), then applies a selectable fs/4 digital upconversion.
- Drives the delta-sigma modulator input at the fast clock rate.
- Adds underrun detection, runtime mode select and saturating negation.

---
 rtl/interp_pkg.sv | 28 ++
 rtl/interp_upconv_fs4_mixer.sv | 42 ++++
 rtl/interp_upconv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// interp_pkg: shared encodings, FSM state type and saturating negation for
// the interpolating fs/4 upconverter.
package interp_pkg;

  localparam logic       INTERP_ZOH = 1'b0;
  localparam logic       INTERP_LIN = 1'b1;

  localparam logic [1:0] MIX_BYP = 2'b00;
  localparam logic [1:0] MIX_COS = 2'b01;
  localparam logic [1:0] MIX_SIN = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Negate a sign-extended w-bit value; the single overflow case
  // -(-2**(w-1)) clamps to the positive full scale 2**(w-1)-1.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] maxv;
    logic signed [63:0] n;
    maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
    n    = -x;
    return (n > maxv) ? maxv : n;
  endfunction

endpackage

// File: rtl/interp_upconv_fs4_mixer.sv
// fs4_mixer: combinational fs/4 mixer.
//   v_i        interpolated sample
//   lo_ph_i    LO quadrant (0..3)
//   mix_mode_i 00 bypass, 01 cos, 10 sin, 11 bypass
//   mix_o      mixed sample (negation saturates)
module fs4_mixer
  import interp_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic signed [DATA_W-1:0] v_i,
  input  logic        [1:0]        lo_ph_i,
  input  logic        [1:0]        mix_mode_i,
  output logic signed [DATA_W-1:0] mix_o
);

  logic signed [DATA_W-1:0] neg;

  assign neg = DATA_W'(sat_neg(64'(v_i), DATA_W));

  always_comb begin
    mix_o = v_i;
    case (mix_mode_i)
      MIX_COS: begin
        case (lo_ph_i)
          2'd0:    mix_o = v_i;
          2'd2:    mix_o = neg;
          default: mix_o = '0;
        endcase
      end
      MIX_SIN: begin
        case (lo_ph_i)
          2'd1:    mix_o = v_i;
          2'd3:    mix_o = neg;
          default: mix_o = '0;
        endcase
      end
      default: mix_o = v_i;
    endcase
  end

endmodule

// File: rtl/interp_upconv.sv
// interp_upconv: upsample slow-rate signed baseband by 2**RATIO_LOG2 (ZOH or
// linear) and apply a selectable fs/4 upconversion, one output per clock.
//   clock_i        fast clock
//   reset_ni       async active-low reset
//   in_data_i      baseband sample, in_valid_i / in_ready_o handshake
//   interp_mode_i  0 ZOH, 1 linear
//   mix_mode_i     00 bypass, 01 cos, 10 sin, 11 bypass
//   clr_underrun_i sync clear of sticky underrun (a new event wins)
//   out_data_o     registered mixed output, out_valid_o its qualifier
//   underrun_o     sticky: a sample was due but in_valid_i was low
module interp_upconv
  import interp_pkg::*;
#(
  parameter int DATA_W     = 20,
  parameter int RATIO_LOG2 = 5
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     interp_mode_i,
  input  logic        [1:0]        mix_mode_i,
  input  logic                     clr_underrun_i,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     out_valid_o,
  output logic                     underrun_o
);

  localparam int ACC_W = DATA_W + RATIO_LOG2 + 1;

  state_e                   state_q, state_d;
  logic [RATIO_LOG2-1:0]    phase_q, phase_d;
  logic signed [DATA_W-1:0] prev_q, prev_d, cur_q, cur_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]               lo_ph_q, lo_ph_d;
  logic                     underrun_q, underrun_d;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;

  logic                     last_ph;
  logic signed [DATA_W:0]   delta;
  logic signed [ACC_W-1:0]  delta_ext, cur_ext, acc_sh;
  logic signed [DATA_W-1:0] v, mix;

  assign last_ph    = &phase_q;
  assign in_ready_o = (state_q == IDLE) || ((state_q == RUN) && last_ph);

  assign delta     = $signed({cur_q[DATA_W-1], cur_q}) - $signed({prev_q[DATA_W-1], prev_q});
  assign delta_ext = $signed({{RATIO_LOG2{delta[DATA_W]}}, delta});
  assign cur_ext   = $signed({{(RATIO_LOG2 + 1){cur_q[DATA_W-1]}}, cur_q});
  // acc holds prev*R + k*delta, so the shift yields prev + floor(k*delta/R)
  assign acc_sh    = acc_q >>> RATIO_LOG2;
  assign v         = (interp_mode_i == INTERP_LIN) ? DATA_W'(acc_sh) : cur_q;

  fs4_mixer #(.DATA_W(DATA_W)) u_mix (
    .v_i       (v),
    .lo_ph_i   (lo_ph_q),
    .mix_mode_i(mix_mode_i),
    .mix_o     (mix)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    acc_d      = acc_q;
    lo_ph_d    = lo_ph_q;
    underrun_d = underrun_q;
    if (clr_underrun_i) underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          cur_d   = in_data_i;
          prev_d  = '0;
          acc_d   = '0;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lo_ph_d = lo_ph_q + 2'd1;
        if (last_ph) begin
          // segment boundary: restart the ramp from the current sample;
          // without a new sample the ramp is flat (cur unchanged)
          prev_d  = cur_q;
          acc_d   = cur_ext <<< RATIO_LOG2;
          phase_d = '0;
          if (in_valid_i) cur_d = in_data_i;
          else            underrun_d = 1'b1;
        end else begin
          phase_d = phase_q + RATIO_LOG2'(1);
          acc_d   = acc_q + delta_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      lo_ph_q     <= '0;
      underrun_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      lo_ph_q     <= lo_ph_d;
      underrun_q  <= underrun_d;
      out_data_q  <= mix;
      out_valid_q <= (state_q == RUN);
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign underrun_o  = underrun_q;

endmodule
